// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Synchronizer reset levels match the idle bus: SCLK low, SS_n high.
  localparam logic SCLK_RST = 1'b0;
  localparam logic SS_N_RST = 1'b1;
  localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a history flop for edge detection.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~hist;
  assign fall = ~s2 & hist;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversampled bus, parallel RX strobe, one-entry TX hold.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = '0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  spi_SCLK,
  input  logic                  spi_SS_n,
  input  logic                  spi_MOSI,
  output logic                  spi_MISO,
  output logic                  spi_MISO_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(SCLK_RST)) u_sclk (
    .clk(clk_clk), .rst(reset_reset), .din(spi_SCLK),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(SS_N_RST)) u_ss (
    .clk(clk_clk), .rst(reset_reset), .din(spi_SS_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RST_VAL(MOSI_RST)) u_mosi (
    .clk(clk_clk), .rst(reset_reset), .din(spi_MOSI),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t state, state_next;
  logic   arm;

  logic [1:0]            primed;
  logic                  seen_high;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  word_done;
  logic                  from_hold;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] shift_tx;
  logic [DATA_WIDTH-1:0] shift_rx;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_done_p1;
  logic                  rx_valid_p2;
  logic                  underrun_q;
  logic                  miso_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall && seen_high) begin
          state_next = ACTIVE;
          arm        = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise)
          state_next = IDLE;
        else if (sclk_fall && bit_cnt == '0 && word_done)
          arm = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      primed      <= '0;
      seen_high   <= 1'b0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      from_hold   <= 1'b0;
      hold_full   <= 1'b0;
      hold        <= '0;
      shift_tx    <= '0;
      shift_rx    <= '0;
      rx_data_q   <= '0;
      rx_done_p1  <= 1'b0;
      rx_valid_p2 <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      rx_done_p1  <= 1'b0;
      rx_valid_p2 <= rx_done_p1;
      underrun_q  <= 1'b0;
      miso_q      <= shift_tx[DATA_WIDTH-1];

      // The SS_n synchronizer holds its reset level for two cycles, so only
      // trust it as evidence of a real deselect once it has flushed.
      if (primed != 2'd2) primed <= primed + 2'd1;
      if (primed == 2'd2 && ss_sync) seen_high <= 1'b1;

      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (arm) begin
        shift_tx  <= hold_full ? hold : FILL_WORD;
        from_hold <= hold_full;
        if (state == IDLE) bit_cnt <= '0;
      end

      if (state == ACTIVE) begin
        if (ss_rise) begin
          bit_cnt   <= '0;
          word_done <= 1'b0;
        end else if (sclk_rise) begin
          shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_sync};
          if (bit_cnt == '0) begin
            if (from_hold) hold_full  <= 1'b0;
            else           underrun_q <= 1'b1;
          end
          if (bit_cnt == LAST_BIT) begin
            rx_data_q  <= {shift_rx[DATA_WIDTH-2:0], mosi_sync};
            rx_done_p1 <= 1'b1;
            word_done  <= 1'b1;
            bit_cnt    <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (sclk_fall && bit_cnt != '0) begin
          shift_tx  <= shift_tx << 1;
          word_done <= 1'b0;
        end
      end
    end
  end

  assign busy        = (state == ACTIVE);
  assign spi_MISO_oe = busy;
  assign spi_MISO    = miso_q & busy;
  assign tx_ready    = ~hold_full;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_p2;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder acting as a mode-0 SPI master.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, ss_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int underrun_cnt = 0;
  logic [7:0] exp_rx[$];

  always #5 clk = ~clk;

  spi_slave_responder #(.DATA_WIDTH(8), .FILL_WORD(8'h00)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .spi_SCLK(sclk), .spi_SS_n(ss_n), .spi_MOSI(mosi),
    .spi_MISO(miso), .spi_MISO_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h expected no word", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
        end
      end
      if (tx_underrun) underrun_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] w);
    int t = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && t < 500) begin
      cyc(1);
      t++;
    end
    check("write_timeout", {31'h0, t < 500}, 32'h1);
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = mo[7-i];
      cyc(8);
      mi   = {mi[6:0], miso};
      sclk = 1'b1;
      cyc(8);
      sclk = 1'b0;
    end
  endtask

  task automatic ss_open();
    ss_n = 1'b0;
    cyc(8);
  endtask

  task automatic ss_close();
    cyc(8);
    ss_n = 1'b1;
    cyc(12);
  endtask

  logic [7:0] m1, m2;
  int u0;

  initial begin
    rst = 1'b1; ss_n = 1'b0; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (6) begin
      sclk = ~sclk;
      cyc(1);
    end
    rst = 1'b0;
    cyc(1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_underrun", {31'h0, tx_underrun}, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    repeat (20) begin
      sclk = ~sclk;
      cyc(4);
    end
    sclk = 1'b0;
    cyc(4);
    check("noarm_busy", {31'h0, busy}, 32'h0);
    check("noarm_underrun_cnt", underrun_cnt, 0);
    ss_n = 1'b1;
    cyc(12);

    // Single word from the hold
    write_word(8'hA5);
    check("hold_full_ready", {31'h0, tx_ready}, 32'h0);
    u0 = underrun_cnt;
    exp_rx.push_back(8'h3C);
    ss_open();
    spi_bits(8, 8'h3C, m1);
    ss_close();
    check("miso_a5", {24'h0, m1}, 32'hA5);
    check("ready_after_a5", {31'h0, tx_ready}, 32'h1);
    check("underrun_a5", underrun_cnt - u0, 0);

    // Back-to-back words, second written while the first shifts
    write_word(8'h81);
    u0 = underrun_cnt;
    exp_rx.push_back(8'h12);
    exp_rx.push_back(8'h34);
    ss_open();
    fork
      begin
        spi_bits(8, 8'h12, m1);
        spi_bits(8, 8'h34, m2);
      end
      write_word(8'h7E);
    join
    ss_close();
    check("miso_81", {24'h0, m1}, 32'h81);
    check("miso_7e", {24'h0, m2}, 32'h7E);
    check("underrun_b2b", underrun_cnt - u0, 0);
    check("ready_after_b2b", {31'h0, tx_ready}, 32'h1);

    // Empty hold: fill word and one underrun
    u0 = underrun_cnt;
    exp_rx.push_back(8'h55);
    ss_open();
    spi_bits(8, 8'h55, m1);
    ss_close();
    check("miso_fill", {24'h0, m1}, 32'h00);
    check("underrun_fill", underrun_cnt - u0, 1);
    check("busy_idle", {31'h0, busy}, 32'h0);

    // Aborted partial word, then a realigned full word
    write_word(8'h5A);
    ss_open();
    spi_bits(5, 8'hF0, m1);
    ss_close();
    check("miso_partial", {24'h0, m1}, 32'h0B);
    check("ready_after_partial", {31'h0, tx_ready}, 32'h1);
    u0 = underrun_cnt;
    exp_rx.push_back(8'hC3);
    ss_open();
    spi_bits(8, 8'hC3, m1);
    ss_close();
    check("miso_after_abort", {24'h0, m1}, 32'h00);
    check("underrun_after_abort", underrun_cnt - u0, 1);

    // Select pulse without SCLK keeps the hold
    write_word(8'h5A);
    ss_n = 1'b0;
    cyc(10);
    ss_n = 1'b1;
    cyc(12);
    check("hold_kept", {31'h0, tx_ready}, 32'h0);
    u0 = underrun_cnt;
    exp_rx.push_back(8'h0F);
    ss_open();
    spi_bits(8, 8'h0F, m1);
    ss_close();
    check("miso_kept_5a", {24'h0, m1}, 32'h5A);
    check("underrun_kept", underrun_cnt - u0, 0);
    check("ready_after_kept", {31'h0, tx_ready}, 32'h1);

    cyc(20);
    check("rx_words_outstanding", exp_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
